// File: rtl/avalon_pio_poll_master_pkg.sv
// Shared types and constants for the Avalon PIO polling master.
package avalon_pio_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CMP     = 3'd3,
        WR_REQ  = 3'd4
    } poll_state_e;

    // Register word offsets inside one Altera-style PIO slave.
    localparam logic [1:0] PIO_DATA      = 2'd0;
    localparam logic [1:0] PIO_DIRECTION = 2'd1;
    localparam logic [1:0] PIO_IRQ_MASK  = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP  = 2'd3;

    // Bits needed to hold a count of 0 .. cycles-1.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/avalon_pio_poll_master_if.sv
// Avalon-MM command/response bundle between the polling master and the fabric.
// Handshake: a command (read or write) is presented with its address/data and held
// unchanged until the cycle where it is high and avm_waitrequest is low; that cycle is
// the accept. Read data arrives a fixed READ_LATENCY clocks after the read accept.
interface avalon_pio_poll_master_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/avalon_pio_poll_master_poll_timer.sv
// Loadable down-counter pacing the polls; holds when neither load nor dec is asserted.
module poll_timer #(
    parameter int          TW     = 10,
    parameter logic [TW-1:0] RELOAD = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (dec) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/avalon_pio_poll_master.sv
// Periodically reads an input PIO over Avalon-MM and mirrors changes to an output PIO.
module avalon_pio_poll_master
    import avalon_pio_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                IN_W         = 6,
    parameter logic [ADDR_W-1:0] IN_ADDR      = 16'h0000,
    parameter logic [ADDR_W-1:0] OUT_ADDR     = 16'h0004,
    parameter int                POLL_CYCLES  = 1000,
    parameter int                READ_LATENCY = 1,
    parameter bit                INVERT       = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    avalon_pio_poll_master_if.master  avm,
    output logic [IN_W-1:0]           value,
    output logic                      change_pulse,
    output logic                      busy,
    output poll_state_e               dbg_state
);
    localparam int            TW           = timer_width(POLL_CYCLES);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_CYCLES - 1);
    localparam logic [1:0]    LAT_RELOAD   = 2'(READ_LATENCY - 1);

    poll_state_e       state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic [IN_W-1:0]   capture_q, capture_d;
    logic [IN_W-1:0]   value_q, value_d;
    logic              first_done_q, first_done_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;

    logic              timer_load, timer_dec, timer_zero;
    logic [IN_W-1:0]   out_bits;
    logic              unused_readdata_hi;

    poll_timer #(.TW(TW), .RELOAD(TIMER_RELOAD)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .dec     (timer_dec),
        .zero    (timer_zero)
    );

    assign out_bits           = INVERT ? ~capture_q : capture_q;
    assign unused_readdata_hi = ^avm.avm_readdata[31:IN_W];

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        capture_d    = capture_q;
        value_d      = value_q;
        first_done_d = first_done_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        pulse_d      = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (timer_zero) begin
                        timer_load = 1'b1;
                        state_d    = RD_REQ;
                        read_d     = 1'b1;
                        address_d  = IN_ADDR;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                if (read_q && !avm.avm_waitrequest) begin
                    read_d    = 1'b0;
                    address_d = '0;
                    lat_d     = LAT_RELOAD;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == 2'd0) begin
                    capture_d = avm.avm_readdata[IN_W-1:0];
                    state_d   = CMP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            CMP: begin
                // The very first poll after reset always writes, even if the input reads 0.
                if (!first_done_q || (capture_q != value_q)) begin
                    value_d      = capture_q;
                    first_done_d = 1'b1;
                    pulse_d      = 1'b1;
                    write_d      = 1'b1;
                    address_d    = OUT_ADDR;
                    writedata_d  = {{(32-IN_W){1'b0}}, out_bits};
                    state_d      = WR_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (write_q && !avm.avm_waitrequest) begin
                    write_d     = 1'b0;
                    address_d   = '0;
                    writedata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= 2'd0;
            capture_q    <= '0;
            value_q      <= '0;
            first_done_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            pulse_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            capture_q    <= capture_d;
            value_q      <= value_d;
            first_done_q <= first_done_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            pulse_q      <= pulse_d;
            busy_q       <= busy_d;
        end
    end

    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_address   = address_q;
    assign avm.avm_writedata = writedata_q;
    assign value             = value_q;
    assign change_pulse      = pulse_q;
    assign busy              = busy_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_avalon_pio_poll_master.sv
// Bench for avalon_pio_poll_master: two instances (plain and inverted) behind stallable PIO slave models.
module tb_avalon_pio_poll_master;
    import avalon_pio_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        en [2];
    logic [5:0]  in_port [2];
    logic [25:0] upper [2];
    int          stall_cfg [2];
    int          stall_left [2] = '{0, 0};

    logic [5:0]  value [2];
    logic        cpulse [2];
    logic        busy [2];
    poll_state_e st [2];

    logic        rd [2], wr [2], wt [2];
    logic [15:0] addr [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;
    int rd_acc [2] = '{0, 0};
    int wr_acc [2] = '{0, 0};
    int pulse_cnt [2] = '{0, 0};

    // {instance, address, writedata} of every write the bench expects to see accepted
    logic [48:0] exp_q [$];

    avalon_pio_poll_master_if #(.ADDR_W(16)) bus0 ();
    avalon_pio_poll_master_if #(.ADDR_W(16)) bus1 ();

    assign rd[0] = bus0.avm_read;   assign rd[1] = bus1.avm_read;
    assign wr[0] = bus0.avm_write;  assign wr[1] = bus1.avm_write;
    assign addr[0] = bus0.avm_address;   assign addr[1] = bus1.avm_address;
    assign wd[0] = bus0.avm_writedata;   assign wd[1] = bus1.avm_writedata;
    assign wt[0] = (rd[0] || wr[0]) && (stall_left[0] != 0);
    assign wt[1] = (rd[1] || wr[1]) && (stall_left[1] != 0);
    assign bus0.avm_waitrequest = wt[0];
    assign bus1.avm_waitrequest = wt[1];
    assign bus0.avm_readdata    = rdata[0];
    assign bus1.avm_readdata    = rdata[1];

    avalon_pio_poll_master #(
        .ADDR_W(16), .IN_W(6), .IN_ADDR(16'h0000), .OUT_ADDR(16'h0004),
        .POLL_CYCLES(4), .READ_LATENCY(1), .INVERT(1'b0)
    ) dut0 (
        .clk(clk), .reset_n(rst_n[0]), .enable(en[0]), .avm(bus0),
        .value(value[0]), .change_pulse(cpulse[0]), .busy(busy[0]), .dbg_state(st[0])
    );

    avalon_pio_poll_master #(
        .ADDR_W(16), .IN_W(6), .IN_ADDR(16'h0000), .OUT_ADDR(16'h0004),
        .POLL_CYCLES(4), .READ_LATENCY(1), .INVERT(1'b1)
    ) dut1 (
        .clk(clk), .reset_n(rst_n[1]), .enable(en[1]), .avm(bus1),
        .value(value[1]), .change_pulse(cpulse[1]), .busy(busy[1]), .dbg_state(st[1])
    );

    // Slave model: stalls each command stall_cfg cycles; readdata valid only one clock after accept.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if ((rd[i] || wr[i]) && stall_left[i] != 0) stall_left[i] <= stall_left[i] - 1;
            else stall_left[i] <= stall_cfg[i];
            if (rd[i] && !wt[i]) rdata[i] <= {upper[i], in_port[i]};
            else rdata[i] <= $urandom;
        end
    end

    // ---------------- bus monitor / scoreboard ----------------
    logic        prev_stall [2] = '{1'b0, 1'b0};
    logic [15:0] prev_addr [2];
    logic [31:0] prev_wd [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i]) begin
                if (rd[i] || wr[i]) begin
                    checks++;
                    if (rd[i] && wr[i]) begin
                        errors++;
                        $display("FAIL rd_wr_exclusive inst%0d: read=%b write=%b, required not both high", i, rd[i], wr[i]);
                    end
                end
                if (prev_stall[i] && (rd[i] || wr[i])) begin
                    checks++;
                    if (addr[i] !== prev_addr[i] || wd[i] !== prev_wd[i]) begin
                        errors++;
                        $display("FAIL stall_stable inst%0d: addr=%h data=%h, required addr=%h data=%h",
                                 i, addr[i], wd[i], prev_addr[i], prev_wd[i]);
                    end
                end
                if (rd[i] && !wt[i]) begin
                    rd_acc[i]++;
                    checks++;
                    if (addr[i] !== 16'h0000) begin
                        errors++;
                        $display("FAIL read_addr inst%0d: got %h, required 0000", i, addr[i]);
                    end
                end
                if (wr[i] && !wt[i]) begin
                    wr_acc[i]++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write inst%0d: addr=%h data=%h, required no write", i, addr[i], wd[i]);
                    end else begin
                        logic [48:0] exp;
                        exp = exp_q.pop_front();
                        if ({1'(i), addr[i], wd[i]} !== exp) begin
                            errors++;
                            $display("FAIL write_txn inst%0d: got inst/addr/data=%h, required %h",
                                     i, {1'(i), addr[i], wd[i]}, exp);
                        end
                    end
                end
                if (cpulse[i]) pulse_cnt[i]++;
                prev_stall[i] = (rd[i] || wr[i]) && wt[i];
                prev_addr[i]  = addr[i];
                prev_wd[i]    = wd[i];
            end else begin
                prev_stall[i] = 1'b0;
            end
        end
    end

    // ---------------- driver / wait tasks ----------------
    task automatic wait_idle(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy[i]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_wr_count(input int i, input int start, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (wr_acc[i] > start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic note_timeout(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_%s: event not seen within bound, required it to occur", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int k;
        bit ok;
        rst_n = '{1'b0, 1'b0};
        en = '{1'b1, 1'b0};
        in_port = '{6'h2A, 6'h00};
        upper = '{26'h0, 26'h0};
        stall_cfg = '{0, 0};
        repeat (3) @(negedge clk);
        checks++;
        if (rd[0] !== 1'b0 || wr[0] !== 1'b0 || busy[0] !== 1'b0 || cpulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: read=%b write=%b busy=%b pulse=%b, required all 0", rd[0], wr[0], busy[0], cpulse[0]);
        end
        checks++;
        if (value[0] !== 6'h00 || addr[0] !== 16'h0 || wd[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: value=%h addr=%h data=%h, required 0", value[0], addr[0], wd[0]);
        end
        exp_q.push_back({1'b0, 16'h0004, 32'h0000002A});
        rst_n[0] = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rd[0]) break;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL first_read_delay: read after %0d clocks, required 4", k);
        end
        ok = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (cpulse[0]) begin ok = 1'b1; break; end
        end
        note_timeout(ok, "first_pulse");
        checks++;
        if (value[0] !== 6'h2A) begin
            errors++;
            $display("FAIL first_value: got %h, required 2a", value[0]);
        end
        @(negedge clk);
        checks++;
        if (cpulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: pulse=%b one clock later, required 0", cpulse[0]);
        end
        wait_wr_count(0, 0, ok);
        note_timeout(ok, "first_write");
    endtask

    task automatic test_no_change();
        int w0, p0, n;
        bit ok;
        w0 = wr_acc[0];
        p0 = pulse_cnt[0];
        ok = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (rd[0] && !wt[0]) begin ok = 1'b1; break; end
        end
        note_timeout(ok, "poll_read");
        n = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            n++;
            if (rd[0] && !wt[0]) break;
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL poll_period: %0d clocks between read accepts, required 7", n);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_acc[0] != w0 || pulse_cnt[0] != p0 || value[0] !== 6'h2A) begin
            errors++;
            $display("FAIL no_change: writes+%0d pulses+%0d value=%h, required +0 +0 2a",
                     wr_acc[0] - w0, pulse_cnt[0] - p0, value[0]);
        end
    endtask

    task automatic test_stall();
        int r0, w0, n;
        bit ok;
        wait_idle(0, ok);
        note_timeout(ok, "stall_idle");
        stall_cfg[0] = 3;
        in_port[0] = 6'h15;
        exp_q.push_back({1'b0, 16'h0004, 32'h00000015});
        r0 = rd_acc[0];
        w0 = wr_acc[0];
        ok = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rd[0]) begin ok = 1'b1; break; end
        end
        note_timeout(ok, "stall_read");
        n = 0;
        while (rd[0] && n < 20) begin n++; @(negedge clk); end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL read_stall_len: read held %0d clocks, required 4", n);
        end
        ok = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (wr[0]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        note_timeout(ok, "stall_write");
        checks++;
        if (value[0] !== 6'h15) begin
            errors++;
            $display("FAIL stall_value: got %h, required 15", value[0]);
        end
        n = 0;
        while (wr[0] && n < 20) begin n++; @(negedge clk); end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL write_stall_len: write held %0d clocks, required 4", n);
        end
        @(negedge clk);
        checks++;
        if (rd_acc[0] - r0 != 1 || wr_acc[0] - w0 != 1) begin
            errors++;
            $display("FAIL stall_accepts: reads=%0d writes=%0d, required 1 and 1", rd_acc[0] - r0, wr_acc[0] - w0);
        end
        stall_cfg[0] = 0;
    endtask

    task automatic test_invert();
        bit ok;
        in_port[1] = 6'h05;
        upper[1] = '1;
        en[1] = 1'b1;
        exp_q.push_back({1'b1, 16'h0004, 32'h0000003A});
        rst_n[1] = 1'b1;
        wait_wr_count(1, 0, ok);
        note_timeout(ok, "invert_write");
        checks++;
        if (value[1] !== 6'h05) begin
            errors++;
            $display("FAIL invert_value: got %h, required 05", value[1]);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (wr_acc[1] != 1 || value[1] !== 6'h05) begin
            errors++;
            $display("FAIL upper_ignored: writes=%0d value=%h, required 1 and 05", wr_acc[1], value[1]);
        end
        rst_n[1] = 1'b0;
        en[1] = 1'b0;
    endtask

    task automatic test_enable_drop();
        int w0, r1, k;
        bit ok;
        wait_idle(0, ok);
        note_timeout(ok, "drop_idle");
        in_port[0] = 6'h33;
        exp_q.push_back({1'b0, 16'h0004, 32'h00000033});
        w0 = wr_acc[0];
        ok = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (st[0] == RD_WAIT) begin ok = 1'b1; break; end
        end
        note_timeout(ok, "reach_rd_wait");
        en[0] = 1'b0;
        wait_wr_count(0, w0, ok);
        note_timeout(ok, "drop_write");
        checks++;
        if (value[0] !== 6'h33) begin
            errors++;
            $display("FAIL drop_value: got %h, required 33", value[0]);
        end
        r1 = rd_acc[0];
        repeat (30) @(negedge clk);
        checks++;
        if (rd_acc[0] != r1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL disabled_quiet: reads+%0d busy=%b, required +0 and 0", rd_acc[0] - r1, busy[0]);
        end
        en[0] = 1'b1;
        repeat (2) @(negedge clk);
        en[0] = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (rd_acc[0] != r1 || rd[0] !== 1'b0) begin
            errors++;
            $display("FAIL partial_enable: reads+%0d read=%b, required +0 and 0", rd_acc[0] - r1, rd[0]);
        end
        en[0] = 1'b1;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rd[0]) break;
        end
        checks++;
        if (k != 2) begin
            errors++;
            $display("FAIL timer_resume: read after %0d clocks, required 2", k);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        bit ok;
        wait_idle(0, ok);
        note_timeout(ok, "rstmid_idle");
        stall_cfg[0] = 3;
        in_port[0] = 6'h0C;
        ok = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (st[0] == WR_REQ && wr[0] && wt[0]) begin ok = 1'b1; break; end
        end
        note_timeout(ok, "reach_wr_req");
        rst_n[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (wr[0] !== 1'b0 || rd[0] !== 1'b0 || busy[0] !== 1'b0 || value[0] !== 6'h00 || wd[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: write=%b read=%b busy=%b value=%h data=%h, required all 0",
                     wr[0], rd[0], busy[0], value[0], wd[0]);
        end
        stall_cfg[0] = 0;
        in_port[0] = 6'h00;
        exp_q.push_back({1'b0, 16'h0004, 32'h00000000});
        @(negedge clk);
        w0 = wr_acc[0];
        rst_n[0] = 1'b1;
        wait_wr_count(0, w0, ok);
        note_timeout(ok, "rewrite_after_reset");
    endtask

    initial begin
        test_reset();
        test_no_change();
        test_stall();
        test_invert();
        test_enable_drop();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
